recip_arbiter: RTL and testbench

- Shares one bit-serial reciprocal engine between NUM_REQ requesters.
- Arbitrates requests round-robin, launches the engine and sequences its iterations, then returns a tagged result on a single response channel with backpressure.
- Sits between the pixel/geometry stages that need 1/x and the single reciprocal datapath, so that unit is not replicated per stage.

---
 rtl/recip_pkg.sv | 16 +
 rtl/recip_seq_core.sv | 78 +++++++
 rtl/recip_arbiter.sv | 133 +++++++++++++
 tb/tb_recip_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/recip_pkg.sv
// Shared constants and types for the reciprocal arbiter slice.
package recip_pkg;

  localparam int unsigned RECIP_W     = 27;
  localparam int unsigned RECIP_SCALE = 26;

  // Result returned for a zero divisor or a saturated quotient (default width).
  localparam logic [RECIP_W-1:0] ALL_ONES = '1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    RESP
  } recip_state_e;

endpackage

// File: rtl/recip_seq_core.sv
// Bit-serial restoring divider computing floor(2^SCALE / num).
// One quotient bit per cycle, MSB first; the first bit is resolved on the
// start edge, so done pulses SCALE+1 cycles after start.
module recip_seq_core
  import recip_pkg::*;
#(
  parameter int unsigned W     = RECIP_W,
  parameter int unsigned SCALE = RECIP_SCALE
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [W-1:0]   num,
  output logic           done,
  output logic [SCALE:0] quotient
);

  localparam int unsigned CW = $clog2(SCALE + 1);

  logic [W-1:0]   num_r;
  logic [W:0]     rem;
  logic [SCALE:0] quo;
  logic [CW-1:0]  idx;
  logic           running;

  logic [W-1:0]   cur_num;
  logic [W:0]     cur_rem;
  logic [SCALE:0] cur_quo;
  logic [CW-1:0]  cur_idx;
  logic [W+1:0]   shifted;
  logic [W+1:0]   ext_num;
  logic           ge;
  logic [W:0]     rem_nxt;
  logic [SCALE:0] quo_nxt;

  // One restoring step; on start the step runs on the fresh operand directly.
  always_comb begin
    cur_num = start ? num : num_r;
    cur_rem = start ? '0 : rem;
    cur_quo = start ? '0 : quo;
    cur_idx = start ? CW'(SCALE) : idx;
    // The dividend 2^SCALE contributes a single 1 at bit position SCALE.
    shifted = {cur_rem, (cur_idx == CW'(SCALE))};
    ext_num = {2'b00, cur_num};
    ge      = (shifted >= ext_num);
    rem_nxt = (W+1)'(ge ? (shifted - ext_num) : shifted);
    quo_nxt = {cur_quo[SCALE-1:0], ge};
  end

  // Residue, quotient and bit-index registers; done pulses after bit 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_r   <= '0;
      rem     <= '0;
      quo     <= '0;
      idx     <= '0;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start || running) begin
        num_r <= cur_num;
        rem   <= rem_nxt;
        quo   <= quo_nxt;
        if (cur_idx == '0) begin
          running <= 1'b0;
          done    <= 1'b1;
        end else begin
          idx     <= cur_idx - CW'(1);
          running <= 1'b1;
        end
      end
    end
  end

  assign quotient = quo;

endmodule

// File: rtl/recip_arbiter.sv
// Round-robin front end sharing one bit-serial reciprocal core between
// NUM_REQ requesters, with a single tagged, back-pressured response channel.
// Define RECIP_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins).
module recip_arbiter
  import recip_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned W       = RECIP_W,
  parameter int unsigned SCALE   = RECIP_SCALE,
  parameter int unsigned ID_W    = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*W-1:0] req_num,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [W-1:0]         rsp_data,
  output logic                 busy
);

  localparam int unsigned XW = ((SCALE + 1) > W) ? (SCALE + 1) : W;

  recip_state_e   state;
  logic [ID_W-1:0] winner;
  logic            found;
  logic [W-1:0]    win_num;
  logic            hs;
  logic            core_start;
  logic            core_done;
  logic [SCALE:0]  core_quo;
  logic [XW-1:0]   quo_x;
  logic [W-1:0]    quo_sat;
  int unsigned     base_idx;
  int unsigned     cand_idx;

`ifndef RECIP_ARB_FIXED_PRIO_EN
  logic [ID_W-1:0] rr_ptr;
`endif

  // Winner search: first valid requester from the priority base, wrapping.
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    cand_idx = 0;
`ifdef RECIP_ARB_FIXED_PRIO_EN
    base_idx = 0;
`else
    base_idx = 32'(rr_ptr);
`endif
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand_idx = base_idx + k;
      if (cand_idx >= NUM_REQ) cand_idx = cand_idx - NUM_REQ;
      if (!found && req_valid[ID_W'(cand_idx)]) begin
        found  = 1'b1;
        winner = ID_W'(cand_idx);
      end
    end
  end

  // Grant is only offered in IDLE; the handshake is the offered grant itself.
  always_comb begin
    req_ready = '0;
    hs        = (state == IDLE) && found;
    win_num   = req_num[winner*W +: W];
    if (hs) req_ready[winner] = 1'b1;
  end

  // Clamp the quotient to W bits when SCALE allows it to exceed 2^W-1.
  always_comb begin
    quo_x   = XW'(core_quo);
    quo_sat = (quo_x > XW'({W{1'b1}})) ? '1 : W'(core_quo);
  end

  assign core_start = hs && (win_num != '0);

  recip_seq_core #(
    .W     (W),
    .SCALE (SCALE)
  ) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (core_start),
    .num      (win_num),
    .done     (core_done),
    .quotient (core_quo)
  );

  // Operation sequencer and response register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rsp_id   <= '0;
      rsp_data <= '0;
`ifndef RECIP_ARB_FIXED_PRIO_EN
      rr_ptr   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (hs) begin
            rsp_id <= winner;
`ifndef RECIP_ARB_FIXED_PRIO_EN
            rr_ptr <= (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + ID_W'(1);
`endif
            if (win_num == '0) begin
              rsp_data <= '1;
              state    <= RESP;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (core_done) begin
            rsp_data <= quo_sat;
            state    <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_recip_arbiter.sv
// Self-checking bench for recip_arbiter: a transaction-level timing/arithmetic
// model checked every cycle, plus literal expectations for directed scenarios.
module tb_recip_arbiter;

  localparam int NUM_REQ = 4;
  localparam int W       = 27;
  localparam int SCALE   = 26;
  localparam int ID_W    = 2;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NUM_REQ-1:0]   req_valid = '0;
  logic [NUM_REQ*W-1:0] req_num = '0;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 rsp_valid;
  logic                 rsp_ready = 1'b1;
  logic [ID_W-1:0]      rsp_id;
  logic [W-1:0]         rsp_data;
  logic                 busy;

  recip_arbiter #(
    .NUM_REQ (NUM_REQ),
    .W       (W),
    .SCALE   (SCALE),
    .ID_W    (ID_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_num   (req_num),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference arithmetic: floor(2^SCALE/num), all-ones for zero or overflow.
  function automatic longint model_recip(input longint n);
    longint q;
    longint maxv;
    maxv = (longint'(1) << W) - 1;
    if (n == 0) return maxv;
    q = (longint'(1) << SCALE) / n;
    if (q > maxv) q = maxv;
    return q;
  endfunction

  // Model state: phase 0 = waiting, 1 = computing, 2 = holding a response.
  int     m_phase = 0;
  int     m_wait = 0;
  int     m_ptr = 0;
  int     m_id = 0;
  longint m_data = 0;
  int     last_hs_cyc = 0;
  int     cur_lat = 0;
  bit     prev_valid = 0;

  int     hs_cyc_q[$];
  int     hs_id_q[$];
  int     acc_cyc_q[$];
  int     rsp_id_q[$];
  longint rsp_data_q[$];
  int     rsp_lat_q[$];

  always @(negedge clk) begin : compare
    logic [NUM_REQ-1:0] exp_ready;
    int w;
    int j;
    longint n;
    if (!rst_n) begin
      chk("reset_req_ready", req_ready, 0);
      chk("reset_rsp_valid", rsp_valid, 0);
      chk("reset_busy", busy, 0);
      chk("reset_rsp_id", rsp_id, 0);
      chk("reset_rsp_data", rsp_data, 0);
      m_phase    = 0;
      m_ptr      = 0;
      prev_valid = 0;
    end else begin
      exp_ready = '0;
      w = -1;
      if (m_phase == 0) begin
        for (int k = 0; k < NUM_REQ; k++) begin
`ifdef RECIP_ARB_FIXED_PRIO_EN
          j = k;
`else
          j = (m_ptr + k) % NUM_REQ;
`endif
          if (w < 0 && req_valid[j]) w = j;
        end
      end
      if (w >= 0) exp_ready[w] = 1'b1;
      chk("req_ready", req_ready, exp_ready);
      chk("busy", busy, (m_phase != 0) ? 1 : 0);
      chk("rsp_valid", rsp_valid, (m_phase == 2) ? 1 : 0);
      if (m_phase == 2) begin
        chk("rsp_id", rsp_id, m_id);
        chk("rsp_data", rsp_data, m_data);
      end
      if (rsp_valid && !prev_valid) cur_lat = cyc - last_hs_cyc;
      prev_valid = rsp_valid;
      case (m_phase)
        0: begin
          if (w >= 0) begin
            n = longint'(req_num[w*W +: W]);
            m_id   = w;
            m_data = model_recip(n);
            m_ptr  = (w + 1) % NUM_REQ;
            last_hs_cyc = cyc;
            hs_cyc_q.push_back(cyc);
            hs_id_q.push_back(w);
            if (n == 0) m_phase = 2;
            else begin
              m_phase = 1;
              m_wait  = SCALE + 1;
            end
          end
        end
        1: begin
          m_wait--;
          if (m_wait == 0) m_phase = 2;
        end
        default: begin
          if (rsp_ready) begin
            rsp_id_q.push_back(int'(rsp_id));
            rsp_data_q.push_back(longint'(rsp_data));
            rsp_lat_q.push_back(cur_lat);
            acc_cyc_q.push_back(cyc);
            m_phase = 0;
          end
        end
      endcase
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    req_valid = '0;
    req_num   = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Raise a request and hold it until granted; returns at posedge+1 after the handshake.
  task automatic issue(input int i, input logic [W-1:0] n);
    bit granted;
    granted = 0;
    req_num[i*W +: W] = n;
    req_valid[i] = 1'b1;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (req_ready[i]) begin
        granted = 1;
        break;
      end
    end
    chk("grant_timeout", granted, 1);
    @(posedge clk);
    #1 req_valid[i] = 1'b0;
  endtask

  task automatic wait_rsp();
    bit seen;
    seen = 0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) begin
        seen = 1;
        break;
      end
    end
    chk("rsp_timeout", seen, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin : stim
    int base;
    int nrsp;
    bit ok;
    logic [NUM_REQ-1:0] g;

    chk("model_pin_div3", model_recip(3), 22369621);
    chk("model_pin_zero", model_recip(0), 134217727);

    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Requester 0, num=1.
    issue(0, 27'd1);
    wait_rsp();
    chk("t1_id", rsp_id_q[$], 0);
    chk("t1_data", rsp_data_q[$], 67108864);
    chk("t1_latency", rsp_lat_q[$], 28);

    // Requester 2, num=3.
    issue(2, 27'd3);
    wait_rsp();
    chk("t2_id", rsp_id_q[$], 2);
    chk("t2_data", rsp_data_q[$], 22369621);

    // Requester 1, zero divisor.
    issue(1, 27'd0);
    wait_rsp();
    chk("t3_id", rsp_id_q[$], 1);
    chk("t3_data", rsp_data_q[$], 134217727);
    chk("t3_latency", rsp_lat_q[$], 1);

    // All four requesters from reset.
    do_reset();
    base = hs_id_q.size();
    nrsp = rsp_data_q.size();
    req_num = {27'd8, 27'd4, 27'd2, 27'd1};
    req_valid = '1;
    ok = 0;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      g = req_valid & req_ready;
      @(posedge clk);
      #1 req_valid = req_valid & ~g;
      if (rsp_data_q.size() >= nrsp + 4) begin
        ok = 1;
        break;
      end
    end
    chk("t4_complete", ok, 1);
    if (ok) begin
      for (int k = 0; k < 4; k++) begin
        chk("t4_grant_order", hs_id_q[base+k], k);
        chk("t4_rsp_id", rsp_id_q[nrsp+k], k);
        chk("t4_data", rsp_data_q[nrsp+k], longint'(67108864 >> k));
      end
    end

    // Backpressure: requester 3 (num=5) held in RESP while requester 0 waits.
    rsp_ready = 1'b0;
    issue(3, 27'd5);
    req_num[0*W +: W] = 27'd7;
    req_valid[0] = 1'b1;
    ok = 0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (rsp_valid) begin
        ok = 1;
        break;
      end
    end
    chk("t5_rsp_seen", ok, 1);
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      chk("t5_hold_data", rsp_data, 13421772);
      chk("t5_hold_id", rsp_id, 3);
      chk("t5_hold_ready", req_ready, 0);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    ok = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (req_ready[0]) begin
        ok = 1;
        break;
      end
    end
    chk("t5_next_grant", ok, 1);
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    wait_rsp();
    chk("t5_id", rsp_id_q[$], 0);
    chk("t5_data", rsp_data_q[$], 9586980);
    chk("t5_prev_data", rsp_data_q[rsp_data_q.size()-2], 13421772);
    chk("t5_grant_gap", hs_cyc_q[$] - acc_cyc_q[acc_cyc_q.size()-2], 1);

    // Reset in RUN cycle 10 drops the operation; a later request completes.
    issue(1, 27'd9);
    nrsp = rsp_data_q.size();
    repeat (9) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", rsp_valid, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_data", rsp_data, 0);
    chk("t6_rst_id", rsp_id, 0);
    chk("t6_rst_ready", req_ready, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue(2, 27'd6);
    wait_rsp();
    chk("t6_rsp_count", rsp_data_q.size(), nrsp + 1);
    chk("t6_id", rsp_id_q[$], 2);
    chk("t6_data", rsp_data_q[$], 11184810);
    chk("t6_latency", rsp_lat_q[$], 28);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
